// File: rtl/print_sequencer.sv
// Serialises one accel/temperature sample frame into an ASCII line, one UART byte at a time.
// Accept to first tx_start: 2 cycles; each byte costs 3 cycles plus UART busy time; line_done follows the last byte.
// Backpressure: waits on tx_busy without timeout; frames arriving mid-line are dropped and counted (PRINT_TEMP_EN adds T field).
module print_sequencer #(
  parameter logic [7:0] FIELD_SEP  = 8'h20,
  parameter int         DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_ready_for_printing,
  input  logic [7:0]            ascii_X1,
  input  logic [7:0]            ascii_X2,
  input  logic [7:0]            ascii_X3,
  input  logic [7:0]            ascii_X4,
  input  logic [7:0]            ascii_Y1,
  input  logic [7:0]            ascii_Y2,
  input  logic [7:0]            ascii_Y3,
  input  logic [7:0]            ascii_Y4,
  input  logic [7:0]            ascii_Z1,
  input  logic [7:0]            ascii_Z2,
  input  logic [7:0]            ascii_Z3,
  input  logic [7:0]            ascii_Z4,
  input  logic [7:0]            ascii_T1,
  input  logic [7:0]            ascii_T2,
  input  logic [7:0]            ascii_T3,
  input  logic [7:0]            ascii_T4,
  input  logic [7:0]            ascii_T5,
  input  logic [7:0]            ascii_T6,
  input  logic                  is_negative_X,
  input  logic                  is_negative_Y,
  input  logic                  is_negative_Z,
  input  logic                  is_negative_T,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  line_done,
  output logic [DROP_CNT_W-1:0] frames_dropped
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, FIN} state_t;

`ifdef PRINT_TEMP_EN
  localparam logic [5:0] LAST_IDX = 6'd34;
`else
  localparam logic [5:0] LAST_IDX = 6'd24;
`endif

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_EQ = 8'h3D;

  state_t                  state_q;
  logic [5:0]              idx_q;
  logic [3:0][7:0]         x_q, y_q, z_q;
  logic                    neg_x_q, neg_y_q, neg_z_q;
  logic [7:0]              tx_data_q;
  logic                    tx_start_q, busy_q, line_done_q;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic [7:0]              byte_d;

`ifdef PRINT_TEMP_EN
  logic [5:0][7:0]         t_q;
  logic                    neg_t_q;
`else
  logic                    unused_t;
  assign unused_t = ^{ascii_T1, ascii_T2, ascii_T3, ascii_T4, ascii_T5, ascii_T6, is_negative_T};
`endif

  function automatic logic [7:0] sign_ch(input logic neg);
    return neg ? 8'h2D : 8'h2B;
  endfunction

  // Packed digit arrays hold the most significant digit in the top slot.
  always_comb begin
    byte_d = 8'h00;
    case (idx_q)
      6'd0:  byte_d = 8'h58;
      6'd1:  byte_d = CH_EQ;
      6'd2:  byte_d = sign_ch(neg_x_q);
      6'd3:  byte_d = x_q[3];
      6'd4:  byte_d = x_q[2];
      6'd5:  byte_d = x_q[1];
      6'd6:  byte_d = x_q[0];
      6'd7:  byte_d = FIELD_SEP;
      6'd8:  byte_d = 8'h59;
      6'd9:  byte_d = CH_EQ;
      6'd10: byte_d = sign_ch(neg_y_q);
      6'd11: byte_d = y_q[3];
      6'd12: byte_d = y_q[2];
      6'd13: byte_d = y_q[1];
      6'd14: byte_d = y_q[0];
      6'd15: byte_d = FIELD_SEP;
      6'd16: byte_d = 8'h5A;
      6'd17: byte_d = CH_EQ;
      6'd18: byte_d = sign_ch(neg_z_q);
      6'd19: byte_d = z_q[3];
      6'd20: byte_d = z_q[2];
      6'd21: byte_d = z_q[1];
      6'd22: byte_d = z_q[0];
`ifdef PRINT_TEMP_EN
      6'd23: byte_d = FIELD_SEP;
      6'd24: byte_d = 8'h54;
      6'd25: byte_d = CH_EQ;
      6'd26: byte_d = sign_ch(neg_t_q);
      6'd27: byte_d = t_q[5];
      6'd28: byte_d = t_q[4];
      6'd29: byte_d = t_q[3];
      6'd30: byte_d = t_q[2];
      6'd31: byte_d = t_q[1];
      6'd32: byte_d = t_q[0];
      6'd33: byte_d = CH_CR;
      6'd34: byte_d = CH_LF;
`else
      6'd23: byte_d = CH_CR;
      6'd24: byte_d = CH_LF;
`endif
      default: byte_d = 8'h00;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (data_ready_for_printing && (state_q != IDLE) && (drop_q != {DROP_CNT_W{1'b1}}))
      drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      neg_x_q     <= 1'b0;
      neg_y_q     <= 1'b0;
      neg_z_q     <= 1'b0;
`ifdef PRINT_TEMP_EN
      t_q         <= '0;
      neg_t_q     <= 1'b0;
`endif
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      tx_start_q  <= 1'b0;
      line_done_q <= 1'b0;
      drop_q      <= drop_d;
      case (state_q)
        IDLE: begin
          if (data_ready_for_printing) begin
            x_q     <= {ascii_X1, ascii_X2, ascii_X3, ascii_X4};
            y_q     <= {ascii_Y1, ascii_Y2, ascii_Y3, ascii_Y4};
            z_q     <= {ascii_Z1, ascii_Z2, ascii_Z3, ascii_Z4};
            neg_x_q <= is_negative_X;
            neg_y_q <= is_negative_Y;
            neg_z_q <= is_negative_Z;
`ifdef PRINT_TEMP_EN
            t_q     <= {ascii_T1, ascii_T2, ascii_T3, ascii_T4, ascii_T5, ascii_T6};
            neg_t_q <= is_negative_T;
`endif
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= byte_d;
            state_q    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (idx_q == LAST_IDX) begin
              line_done_q <= 1'b1;
              state_q     <= FIN;
            end else begin
              idx_q   <= idx_q + 6'd1;
              state_q <= SEND;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_start       = tx_start_q;
  assign busy           = busy_q;
  assign line_done      = line_done_q;
  assign frames_dropped = drop_q;

endmodule

// File: tb/tb_print_sequencer.sv
// Directed bench for print_sequencer with a simple UART TX model that captures every started byte.
// Expected lines are hand-written constants, chosen by PRINT_TEMP_EN to match the build.
module tb_print_sequencer;

  logic       clk, reset, drdy;
  logic [7:0] ax1, ax2, ax3, ax4, ay1, ay2, ay3, ay4, az1, az2, az3, az4;
  logic [7:0] at1, at2, at3, at4, at5, at6;
  logic       nx, ny, nz, nt;
  logic       tx_busy, hold_busy;
  logic [7:0] tx_data;
  logic       tx_start, busy, line_done;
  logic [7:0] frames_dropped;

  int         n_run = 0;
  int         n_fail = 0;
  int         busy_cnt = 0;
  int         uart_len = 10;
  int         cap_n = 0;
  int         st_cnt = 0;
  int         ld_cnt = 0;
  logic [7:0] cap [4096];

`ifdef PRINT_TEMP_EN
  string line_a = "X=+1234 Y=-0005 Z=+9999 T=+012345\r\n";
  string line_b = "X=-0042 Y=+7777 Z=-0000 T=-999999\r\n";
`else
  string line_a = "X=+1234 Y=-0005 Z=+9999\r\n";
  string line_b = "X=-0042 Y=+7777 Z=-0000\r\n";
`endif

  print_sequencer #(.FIELD_SEP(8'h20), .DROP_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .data_ready_for_printing(drdy),
    .ascii_X1(ax1), .ascii_X2(ax2), .ascii_X3(ax3), .ascii_X4(ax4),
    .ascii_Y1(ay1), .ascii_Y2(ay2), .ascii_Y3(ay3), .ascii_Y4(ay4),
    .ascii_Z1(az1), .ascii_Z2(az2), .ascii_Z3(az3), .ascii_Z4(az4),
    .ascii_T1(at1), .ascii_T2(at2), .ascii_T3(at3), .ascii_T4(at4), .ascii_T5(at5), .ascii_T6(at6),
    .is_negative_X(nx), .is_negative_Y(ny), .is_negative_Z(nz), .is_negative_T(nt),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
    .line_done(line_done), .frames_dropped(frames_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0) || hold_busy;

  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (tx_start) begin
      if (cap_n < 4096) cap[cap_n] <= tx_data;
      cap_n    <= cap_n + 1;
      busy_cnt <= uart_len;
    end
    if (tx_start)  st_cnt <= st_cnt + 1;
    if (line_done) ld_cnt <= ld_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_frame(input string xs, input string ys, input string zs, input string ts,
                           input logic [3:0] neg);
    ax1 = xs[0]; ax2 = xs[1]; ax3 = xs[2]; ax4 = xs[3];
    ay1 = ys[0]; ay2 = ys[1]; ay3 = ys[2]; ay4 = ys[3];
    az1 = zs[0]; az2 = zs[1]; az3 = zs[2]; az4 = zs[3];
    at1 = ts[0]; at2 = ts[1]; at3 = ts[2]; at4 = ts[3]; at5 = ts[4]; at6 = ts[5];
    {nx, ny, nz, nt} = neg;
  endtask

  task automatic pulse();
    @(negedge clk) drdy = 1'b1;
    @(negedge clk) drdy = 1'b0;
  endtask

  task automatic wait_ld(input string tag, input int prev);
    for (int k = 0; k < 4000 && ld_cnt == prev; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(tag, ld_cnt - prev, 1);
  endtask

  task automatic check_line(input string tag, input int base, input string exp);
    chk({tag, "_len"}, cap_n - base, exp.len());
    for (int i = 0; i < exp.len(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'h0, cap[base + i]}, {24'h0, exp[i]});
  endtask

  initial begin
    int base, ld0, st0;
    reset = 1'b0; drdy = 1'b0; hold_busy = 1'b0;
    set_frame("0000", "0000", "0000", "000000", 4'b0000);

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_dropped", frames_dropped, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", st_cnt, 0);
    chk("idle_busy", busy, 0);

    // Basic line
    base = cap_n; ld0 = ld_cnt;
    set_frame("1234", "0005", "9999", "012345", 4'b0100);
    pulse();
    chk("accept_busy", busy, 1);
    wait_ld("line_a_done", ld0);
    check_line("line_a", base, line_a);
    chk("line_a_busy_after", busy, 0);
    chk("line_a_dropped", frames_dropped, 0);

    // Drop while in flight, snapshot isolation, saturation
    uart_len = 30;
    base = cap_n; ld0 = ld_cnt;
    set_frame("0042", "7777", "0000", "999999", 4'b1011);
    pulse();
    set_frame("1234", "0005", "9999", "012345", 4'b0100);
    for (int k = 0; k < 4000 && (cap_n - base) < 10; k++) @(posedge clk);
    pulse();
    chk("drop_one", frames_dropped, 1);
    @(negedge clk) drdy = 1'b1;
    repeat (300) @(negedge clk);
    drdy = 1'b0;
    chk("drop_sat", frames_dropped, 255);
    chk("drop_still_busy", busy, 1);
    wait_ld("line_b_done", ld0);
    check_line("line_b", base, line_b);
    chk("drop_sat_hold", frames_dropped, 255);
    uart_len = 10;

    // tx_busy held high before the frame
    hold_busy = 1'b1;
    base = cap_n; ld0 = ld_cnt; st0 = st_cnt;
    pulse();
    repeat (30) @(negedge clk);
    chk("hold_no_start", st_cnt - st0, 0);
    chk("hold_busy_out", busy, 1);
    hold_busy = 1'b0;
    for (int k = 0; k < 200 && cap_n == base; k++) @(posedge clk);
    @(negedge clk);
    chk("hold_first_byte", {24'h0, cap[base]}, 32'h58);
    wait_ld("hold_line_done", ld0);
    chk("hold_line_len", cap_n - base, line_a.len());

    // Reset in the middle of a line
    base = cap_n;
    pulse();
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      if (tx_start && (cap_n - base) == 20) break;
    end
    chk("mid_start_seen", tx_start, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dropped", frames_dropped, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    st0 = st_cnt;
    repeat (5) @(negedge clk);
    chk("mid_no_resume", st_cnt - st0, 0);
    base = cap_n; ld0 = ld_cnt;
    pulse();
    wait_ld("restart_done", ld0);
    check_line("restart", base, line_a);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
